// File: rtl/lfa_adc_reader.sv
// lfa_adc_reader: SPI master for the ADC128S022 on the LFA board.
// Samples the left/middle/right channels round-robin and publishes the most
// recent 12-bit readings, with a one-cycle strobe per refreshed triple.
module lfa_adc_reader #(
  parameter logic [2:0]  CH_LEFT   = 3'd3,
  parameter logic [2:0]  CH_MIDDLE = 3'd4,
  parameter logic [2:0]  CH_RIGHT  = 3'd5,
  parameter int unsigned CS_GAP    = 2
) (
  input  logic        clk_3125KHz,
  input  logic        rst_n,
  input  logic        en,
  input  logic        adc_dout,
  output logic        adc_cs_n,
  output logic        adc_sck,
  output logic        adc_din,
  output logic [11:0] left,
  output logic [11:0] middle,
  output logic [11:0] right,
  output logic        sample_valid
);

  typedef enum logic [1:0] {S_GAP, S_XFER, S_LATCH} state_t;
  typedef enum logic [1:0] {SL_LEFT, SL_MIDDLE, SL_RIGHT} slot_t;
  typedef enum logic [1:0] {P_NONE, P_LEFT, P_MIDDLE, P_RIGHT} pend_t;

  localparam logic [3:0] GAP_LAST = 4'(CS_GAP - 1);

  state_t      state, next_state;
  slot_t       slot;
  pend_t       pending;
  logic [3:0]  gap_cnt;
  logic [4:0]  c;
  logic [3:0]  k;
  logic [11:0] shift;
  logic [2:0]  addr;

  assign k = c[4:1];

  // State register
  always_ff @(posedge clk_3125KHz or negedge rst_n) begin
    if (!rst_n) state <= S_GAP;
    else        state <= next_state;
  end

  // Next-state decode: en is only looked at when the gap has elapsed
  always_comb begin
    next_state = state;
    unique case (state)
      S_GAP:   if (gap_cnt == GAP_LAST && en) next_state = S_XFER;
      S_XFER:  if (c == 5'd31) next_state = S_LATCH;
      S_LATCH: next_state = S_GAP;
      default: next_state = S_GAP;
    endcase
  end

  // Channel address of the slot currently being converted
  always_comb begin
    unique case (slot)
      SL_LEFT:   addr = CH_LEFT;
      SL_MIDDLE: addr = CH_MIDDLE;
      SL_RIGHT:  addr = CH_RIGHT;
      default:   addr = CH_LEFT;
    endcase
  end

  // SPI pin decode: sck low on even c, address bits on k=2..4
  always_comb begin
    adc_cs_n = 1'b1;
    adc_sck  = 1'b1;
    adc_din  = 1'b0;
    if (state == S_XFER) begin
      adc_cs_n = 1'b0;
      adc_sck  = c[0];
      unique case (k)
        4'd2:    adc_din = addr[2];
        4'd3:    adc_din = addr[1];
        4'd4:    adc_din = addr[0];
        default: adc_din = 1'b0;
      endcase
    end
  end

  // Counters, sample capture, slot/pending rotation and result write
  always_ff @(posedge clk_3125KHz or negedge rst_n) begin
    if (!rst_n) begin
      gap_cnt      <= '0;
      c            <= '0;
      slot         <= SL_LEFT;
      pending      <= P_NONE;
      shift        <= '0;
      left         <= '0;
      middle       <= '0;
      right        <= '0;
      sample_valid <= 1'b0;
    end else begin
      sample_valid <= 1'b0;

      if (state == S_LATCH)
        gap_cnt <= '0;
      else if (state == S_GAP && gap_cnt != GAP_LAST)
        gap_cnt <= gap_cnt + 4'd1;

      // Parking restarts the rotation so the first frame back is discarded
      if (state == S_GAP && gap_cnt == GAP_LAST && !en) begin
        slot    <= SL_LEFT;
        pending <= P_NONE;
      end

      if (state == S_XFER) c <= c + 5'd1;
      else                 c <= '0;

      if (state == S_XFER && !c[0] && k >= 4'd4)
        shift <= {shift[10:0], adc_dout};

      if (state == S_LATCH) begin
        unique case (pending)
          P_LEFT:   left   <= shift;
          P_MIDDLE: middle <= shift;
          P_RIGHT: begin
            right        <= shift;
            sample_valid <= 1'b1;
          end
          default: ;
        endcase
        unique case (slot)
          SL_LEFT:   begin pending <= P_LEFT;   slot <= SL_MIDDLE; end
          SL_MIDDLE: begin pending <= P_MIDDLE; slot <= SL_RIGHT;  end
          default:   begin pending <= P_RIGHT;  slot <= SL_LEFT;   end
        endcase
      end
    end
  end

endmodule
